multi_lane_tx_striper: RTL and testbench

//  Next-generation TX front end for x1..xNUM_LANES links. Takes a byte stream (data or K symbols) with a

---
 rtl/multi_lane_tx_striper.sv | 162 ++++++++++++++++
 tb/tb_multi_lane_tx_striper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_tx_striper.sv
// multi_lane_tx_striper
//   TX front end for x1..xNUM_LANES links. Accepts a byte stream (data or K
//   symbols) over a valid/ready handshake, stripes bytes round-robin across
//   the active lanes, scrambles data bytes with a per-lane PCIe Gen1 LFSR,
//   and emits one lane-aligned symbol word per output handshake.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   link_width_i           active lanes W = 2**link_width_i, clamped to NUM_LANES
//   bypass_scrambler_i     data bytes pass unscrambled (LFSR still advances)
//   flush_i                drop partial word, reseed all LFSRs
//   data_i/is_k_i          input byte and K flag
//   data_valid_i/_ready_o  input handshake
//   lane_symbol_o          lane n symbol at [8n+7:8n]
//   lane_is_k_o            per-lane K flag
//   lane_valid_o           lanes < W of the held word
//   word_valid_o/_ready_i  output handshake
module multi_lane_tx_striper #(
  parameter int unsigned NUM_LANES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF,
  localparam int unsigned WIDTH_W  = $clog2(NUM_LANES) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH_W-1:0]     link_width_i,
  input  logic                   bypass_scrambler_i,
  input  logic                   flush_i,
  input  logic [7:0]             data_i,
  input  logic                   is_k_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic [NUM_LANES*8-1:0] lane_symbol_o,
  output logic [NUM_LANES-1:0]   lane_is_k_o,
  output logic [NUM_LANES-1:0]   lane_valid_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i
);

  localparam int unsigned LOG_N = $clog2(NUM_LANES);
  localparam int unsigned IDX_W = (NUM_LANES > 1) ? LOG_N : 1;

  // Advance the Galois LFSR (x^16+x^5+x^4+x^3+1) by 8 shifts.
  // Returns {8 output bits (bit0 first), next LFSR state}.
  function automatic logic [23:0] scr8(input logic [15:0] s);
    logic [15:0] st;
    logic [7:0]  m;
    logic        fb;
    st = s;
    m  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      fb   = st[15];
      m[i] = fb;
      st   = {st[14:0], 1'b0} ^ (fb ? 16'h0039 : 16'h0000);
    end
    return {m, st};
  endfunction

  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH_W-1:0] wlog_q;
  logic [WIDTH_W-1:0] wlog_in;
  logic [WIDTH_W-1:0] wlog_eff;
  logic [15:0]        lfsr_q [NUM_LANES];
  logic [7:0]         asm_sym_q [NUM_LANES];
  logic [NUM_LANES-1:0] asm_k_q;

  logic [31:0]        w_lanes;
  logic               last_lane;
  logic               accept;
  logic [15:0]        cur_lfsr;
  logic [23:0]        scr_res;
  logic               is_com;
  logic               is_skp;
  logic [7:0]         sym_out;
  logic [15:0]        lfsr_upd;

  logic [NUM_LANES*8-1:0] word_sym_d;
  logic [NUM_LANES-1:0]   word_k_d;
  logic [NUM_LANES-1:0]   word_lv_d;

  // Width is sampled only on the first byte of a word; mid-word the latched
  // value governs, so a width change takes effect at the next word boundary.
  always_comb begin
    wlog_in  = (32'(link_width_i) > LOG_N) ? WIDTH_W'(LOG_N) : link_width_i;
    wlog_eff = (idx_q == '0) ? wlog_in : wlog_q;
    w_lanes  = 32'd1 << wlog_eff;
    last_lane = (32'(idx_q) == (w_lanes - 32'd1));
  end

  assign data_ready_o = !flush_i && !(word_valid_o && !word_ready_i && last_lane);
  assign accept       = data_valid_i && data_ready_o;

  always_comb begin
    cur_lfsr = lfsr_q[idx_q];
    scr_res  = scr8(cur_lfsr);
    is_com   = is_k_i && (data_i == 8'hBC);
    is_skp   = is_k_i && (data_i == 8'h1C);
    sym_out  = (is_k_i || bypass_scrambler_i) ? data_i : (data_i ^ scr_res[23:16]);
    if (is_com)      lfsr_upd = LFSR_SEED;
    else if (is_skp) lfsr_upd = cur_lfsr;
    else             lfsr_upd = scr_res[15:0];
  end

  // Completed word: earlier lanes from the assembly buffer, the current lane
  // straight from the incoming byte, idle lanes forced to zero.
  always_comb begin
    word_sym_d = '0;
    word_k_d   = '0;
    word_lv_d  = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (l < w_lanes) begin
        word_lv_d[l] = 1'b1;
        if (l == 32'(idx_q)) begin
          word_sym_d[l*8 +: 8] = sym_out;
          word_k_d[l]          = is_k_i;
        end else begin
          word_sym_d[l*8 +: 8] = asm_sym_q[l];
          word_k_d[l]          = asm_k_q[l];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      wlog_q  <= '0;
      asm_k_q <= '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        lfsr_q[l]    <= LFSR_SEED;
        asm_sym_q[l] <= '0;
      end
    end else if (flush_i) begin
      idx_q <= '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        lfsr_q[l] <= LFSR_SEED;
      end
    end else if (accept) begin
      lfsr_q[idx_q]    <= lfsr_upd;
      asm_sym_q[idx_q] <= sym_out;
      asm_k_q[idx_q]   <= is_k_i;
      wlog_q           <= wlog_eff;
      idx_q            <= last_lane ? '0 : idx_q + 1'b1;
    end
  end

  // A new word may load in the same cycle the held one is taken: no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_valid_o  <= 1'b0;
      lane_symbol_o <= '0;
      lane_is_k_o   <= '0;
      lane_valid_o  <= '0;
    end else if (accept && last_lane) begin
      word_valid_o  <= 1'b1;
      lane_symbol_o <= word_sym_d;
      lane_is_k_o   <= word_k_d;
      lane_valid_o  <= word_lv_d;
    end else if (word_ready_i) begin
      word_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_lane_tx_striper.sv
module tb_multi_lane_tx_striper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  link_width = 3'd2;
  logic        bypass = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        is_k = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [31:0] lane_symbol;
  logic [3:0]  lane_is_k;
  logic [3:0]  lane_valid;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        rdy_seen;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  multi_lane_tx_striper #(.NUM_LANES(4), .LFSR_SEED(16'hFFFF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .link_width_i(link_width),
    .bypass_scrambler_i(bypass), .flush_i(flush), .data_i(data), .is_k_i(is_k),
    .data_valid_i(data_valid), .data_ready_o(data_ready),
    .lane_symbol_o(lane_symbol), .lane_is_k_o(lane_is_k), .lane_valid_o(lane_valid),
    .word_valid_o(word_valid), .word_ready_i(word_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge, sample ready before the edge, return 1ns after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic k, input logic byp,
                      input logic [2:0] lw, input logic wr, input logic fl);
    @(negedge clk);
    data_valid = v; data = d; is_k = k; bypass = byp;
    link_width = lw; word_ready = wr; flush = fl;
    #1 rdy_seen = data_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string name, input logic [31:0] es, input logic [3:0] ek,
                            input logic [3:0] elv);
    check({name, ".valid"}, 32'(word_valid), 32'd1);
    check({name, ".sym"}, lane_symbol, es);
    check({name, ".k"}, 32'(lane_is_k), 32'(ek));
    check({name, ".lv"}, 32'(lane_valid), 32'(elv));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; data_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        k;
    logic        byp;
    logic [2:0]  lw;
    logic        chk;
    logic [31:0] es;
    logic [3:0]  ek;
    logic [3:0]  elv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic k, input logic byp,
                              input logic [2:0] lw, input logic chk, input logic [31:0] es,
                              input logic [3:0] ek, input logic [3:0] elv);
    vec_t v;
    v.d = d; v.k = k; v.byp = byp; v.lw = lw; v.chk = chk; v.es = es; v.ek = ek; v.elv = elv;
    return v;
  endfunction

  // Reference scrambler: polynomial x^16+x^5+x^4+x^3+1 as integer arithmetic.
  function automatic int unsigned lfsr_adv(input int unsigned s);
    int unsigned t = s;
    for (int i = 0; i < 8; i++) begin
      if (((t >> 15) & 1) != 0) t = ((t << 1) & 32'hFFFF) ^ 32'h39;
      else                      t = (t << 1) & 32'hFFFF;
    end
    return t;
  endfunction

  function automatic int unsigned lfsr_prn(input int unsigned s);
    int unsigned t = s;
    int unsigned m = 0;
    for (int i = 0; i < 8; i++) begin
      m = m | (((t >> 15) & 1) << i);
      if (((t >> 15) & 1) != 0) t = ((t << 1) & 32'hFFFF) ^ 32'h39;
      else                      t = (t << 1) & 32'hFFFF;
    end
    return m;
  endfunction

  // Model state
  int unsigned m_lfsr[4];
  int unsigned m_asm[4];
  int unsigned m_asmk[4];
  int unsigned m_idx, m_width;
  logic        m_ov;
  logic [31:0] m_sym;
  logic [3:0]  m_k, m_lv;

  initial begin
    // 1: reset state
    #3;
    check("rst.valid", 32'(word_valid), 32'd0);
    check("rst.ready", 32'(data_ready), 32'd1);
    check("rst.lv", 32'(lane_valid), 32'd0);
    check("rst.sym", lane_symbol, 32'd0);
    rst_n = 1'b1;

    // 2..5: directed table
    for (int i = 0; i < 4; i++) tbl.push_back(mk(8'hBC, 1, 0, 2, i == 3, 32'hBCBCBCBC, 4'hF, 4'hF));
    for (int w = 0; w < 3; w++) begin
      logic [7:0] sc;
      sc = (w == 0) ? 8'hFF : (w == 1) ? 8'h17 : 8'hC0;
      for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h00, 0, 0, 2, i == 3, {4{sc}}, 4'h0, 4'hF));
    end
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(8'(i), 0, 1, 2, (i == 4) || (i == 8),
                       (i == 4) ? 32'h04030201 : 32'h08070605, 4'h0, 4'hF));
    tbl.push_back(mk(8'hBC, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(8'hBC, 1, 0, 1, 1, 32'h0000BCBC, 4'h3, 4'h3));
    tbl.push_back(mk(8'hAA, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(8'h55, 0, 0, 1, 1, 32'h0000AA55, 4'h0, 4'h3));
    tbl.push_back(mk(8'hBC, 1, 0, 0, 1, 32'h000000BC, 4'h1, 4'h1));
    tbl.push_back(mk(8'h1C, 1, 0, 0, 1, 32'h0000001C, 4'h1, 4'h1));
    tbl.push_back(mk(8'h00, 0, 0, 0, 1, 32'h000000FF, 4'h0, 4'h1));

    foreach (tbl[i]) begin
      step(1, tbl[i].d, tbl[i].k, tbl[i].byp, tbl[i].lw, 1, 0);
      check($sformatf("tbl%0d.ready", i), 32'(rdy_seen), 32'd1);
      if (tbl[i].chk) check_word($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ek, tbl[i].elv);
    end
    step(0, 0, 0, 0, 2, 1, 0);
    check("idle.valid", 32'(word_valid), 32'd0);

    // 6a: backpressure with a held word and 3 of 4 bytes assembled
    step(1, 8'h11, 0, 1, 2, 0, 0);
    step(1, 8'h22, 0, 1, 2, 0, 0);
    step(1, 8'h33, 0, 1, 2, 0, 0);
    step(1, 8'h44, 0, 1, 2, 0, 0);
    check_word("bp.held", 32'h44332211, 4'h0, 4'hF);
    step(1, 8'h55, 0, 1, 2, 0, 0);
    step(1, 8'h66, 0, 1, 2, 0, 0);
    step(1, 8'h77, 0, 1, 2, 0, 0);
    check("bp.ready3", 32'(rdy_seen), 32'd1);
    step(1, 8'h88, 0, 1, 2, 0, 0);
    check("bp.stall", 32'(rdy_seen), 32'd0);
    check_word("bp.stable", 32'h44332211, 4'h0, 4'hF);
    step(1, 8'h88, 0, 1, 2, 1, 0);
    check("bp.release", 32'(rdy_seen), 32'd1);
    check_word("bp.next", 32'h88776655, 4'h0, 4'hF);
    step(0, 0, 0, 0, 2, 1, 0);
    check("bp.drain", 32'(word_valid), 32'd0);

    // 6b: flush after 2 bytes while a word is held
    for (int i = 1; i <= 4; i++) step(1, 8'hA0 + 8'(i), 0, 1, 2, 0, 0);
    step(1, 8'h00, 0, 0, 2, 0, 0);
    step(1, 8'h00, 0, 0, 2, 0, 0);
    step(1, 8'h00, 0, 0, 2, 0, 1);
    check("fl.ready", 32'(rdy_seen), 32'd0);
    check_word("fl.held", 32'hA4A3A2A1, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 0, 2, 1, 0);
    check_word("fl.reseed", 32'hFFFFFFFF, 4'h0, 4'hF);

    // Reset mid-word: no partial word, LFSRs reseeded
    step(1, 8'h00, 0, 0, 2, 1, 0);
    step(1, 8'h00, 0, 0, 2, 1, 0);
    @(negedge clk);
    data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst.valid", 32'(word_valid), 32'd0);
    check("mrst.ready", 32'(data_ready), 32'd1);
    check("mrst.lv", 32'(lane_valid), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 0, 2, 1, 0);
    check_word("mrst.word", 32'hFFFFFFFF, 4'h0, 4'hF);

    // Randomized run against the reference model
    do_reset();
    for (int l = 0; l < 4; l++) begin m_lfsr[l] = 32'hFFFF; m_asm[l] = 0; m_asmk[l] = 0; end
    m_idx = 0; m_width = 1; m_ov = 0; m_sym = '0; m_k = '0; m_lv = '0;
    begin
      logic [2:0] lw_r;
      lw_r = 3'd2;
      for (int c = 0; c < 3000; c++) begin
        logic v, k, byp, wr, fl, acc, exp_rdy, last;
        logic [7:0] d;
        int unsigned eff_w, ob;
        v   = ($urandom_range(0, 3) != 0);
        wr  = ($urandom_range(0, 9) < 7);
        fl  = ($urandom_range(0, 39) == 0);
        byp = ($urandom_range(0, 9) == 0);
        k   = ($urandom_range(0, 4) == 0);
        case ($urandom_range(0, 2))
          0: d = 8'hBC;
          1: d = 8'h1C;
          default: d = 8'($urandom);
        endcase
        if (!k) d = 8'($urandom);
        if ($urandom_range(0, 19) == 0) lw_r = 3'($urandom_range(0, 7));

        // Width takes effect only at the start of a word
        eff_w   = (m_idx == 0) ? (1 << ((lw_r > 2) ? 2 : int'(lw_r))) : m_width;
        last    = (m_idx == eff_w - 1);
        exp_rdy = !fl && !(m_ov && !wr && last);
        acc     = v && exp_rdy;

        step(v, d, k, byp, lw_r, wr, fl);
        check("rnd.ready", 32'(rdy_seen), 32'(exp_rdy));

        if (fl) begin
          m_idx = 0;
          for (int l = 0; l < 4; l++) m_lfsr[l] = 32'hFFFF;
          if (wr) m_ov = 0;
        end else if (acc) begin
          if (k || byp) ob = d;
          else          ob = d ^ lfsr_prn(m_lfsr[m_idx]);
          if (k && d == 8'hBC)      m_lfsr[m_idx] = 32'hFFFF;
          else if (!(k && d == 8'h1C)) m_lfsr[m_idx] = lfsr_adv(m_lfsr[m_idx]);
          m_asm[m_idx] = ob; m_asmk[m_idx] = k;
          m_width = eff_w;
          if (last) begin
            m_ov = 1; m_sym = '0; m_k = '0; m_lv = '0;
            for (int l = 0; l < 4; l++) if (l < eff_w) begin
              m_sym[l*8 +: 8] = 8'(m_asm[l]);
              m_k[l] = m_asmk[l][0];
              m_lv[l] = 1'b1;
            end
            m_idx = 0;
          end else begin
            m_idx++;
            if (wr) m_ov = 0;
          end
        end else if (wr) begin
          m_ov = 0;
        end

        check("rnd.valid", 32'(word_valid), 32'(m_ov));
        if (m_ov) begin
          check("rnd.sym", lane_symbol, m_sym);
          check("rnd.k", 32'(lane_is_k), 32'(m_k));
          check("rnd.lv", 32'(lane_valid), 32'(m_lv));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
